mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, shall set the width of the data path and the memory word.
REQ-002 Parameter ADDR_WIDTH, default 32, shall set the width of PC and address.
REQ-003 Parameter INST_WIDTH, default 32, shall set the instruction width.
REQ-004 Parameter REG_WIDTH, default 5, shall set the register-address width.
REQ-005 Parameter LSU_OP_WIDTH, default 4, shall set the width of the LSU opcode. Encoding: 0 NONE, 1 LD_B, 2 LD_H, 3 LD_W, 4 LD_BU, 5 LD_HU, 6 ST_B, 7 ST_H, 8 ST_W; other values are treated as NONE.
REQ-006 Clock and reset shall be as follows: single clock domain; reset is synchronous and active-low.
REQ-007 clk  in  1  clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 ex_valid / ex_ready  in / out  1  upstream EX-stage handshake.
REQ-010 ex_inst, ex_pc, ex_result, ex_rd_wr_en, ex_rd_wr_addr, ex_lsu_data, ex_lsu_op  in  INST/ADDR/DATA/1/REG/DATA/LSU_OP  EX-stage payload. ex_result carries the memory address for loads and stores.
REQ-011 dm_req, dm_we  out  1  data-memory request and write enable.
REQ-012 dm_addr  out  ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}.
REQ-013 dm_wdata, dm_wstrb  out  DATA_WIDTH, 4  store data and byte strobes.
REQ-014 dm_gnt, dm_rvalid  in  1  request accepted; load data valid.
REQ-015 dm_rdata  in  DATA_WIDTH  load word.
REQ-016 wb_valid / wb_ready  out / in  1  downstream WB handshake.
REQ-017 wb_inst, wb_pc, wb_result, wb_rd_wr_en, wb_rd_wr_addr  out  as the EX payload  registered WB payload.
REQ-018 wb_ale  out  1  address-misalignment flag.

Function
REQ-019 The FSM shall have three states: IDLE, REQ, RESP.
REQ-020 ex_ready shall be high only when state is IDLE and (!wb_valid || wb_ready).
REQ-021 An EX instruction shall be accepted when ex_valid && ex_ready are both high.
REQ-022 A NONE op accepted in IDLE shall load the output register next cycle with wb_result=ex_result and rd_wr_en passed through.
  - Latency is 1 cycle.
  - Back-to-back NONE ops shall sustain 1 per cycle while wb_ready=1.
REQ-023 A misaligned access shall go to the output register next cycle without asserting dm_req. The output shall carry wb_ale=1, wb_rd_wr_en=0, wb_result=address.
  - Misaligned means: H/HU/ST_H with addr[0]=1, or W/ST_W with addr[1:0]!=0.
REQ-024 An aligned load or store shall capture the payload and enter REQ.
REQ-025 In REQ, dm_req shall be 1 and dm_addr/dm_we/dm_wdata/dm_wstrb shall stay stable until dm_gnt is high.
REQ-026 Store write data shall be:
  - ST_B: wdata={4{b}}, wstrb=0001<<off.
  - ST_H: wdata={2{h}}, wstrb=0011<<off.
  - ST_W: wdata=word, wstrb=1111.
  - off=addr[1:0].
REQ-027 A store shall complete on the dm_gnt cycle: output loaded next cycle with wb_rd_wr_en=0, wb_result=address; state returns to IDLE.
REQ-028 A load shall enter RESP on dm_gnt with dm_req deasserted; dm_rvalid seen in REQ shall be ignored.
REQ-029 In RESP, when dm_rvalid=1, the selected byte/half at offset off shall be sign-extended (B,H) or zero-extended (BU,HU), or the full word taken (W), into wb_result. The output shall load next cycle and state shall return to IDLE.
REQ-030 wb payload shall hold stable while wb_valid && !wb_ready.
REQ-031 wb_valid shall clear after a handshake unless a new result loads in the same cycle.
REQ-032 dm_req shall never be asserted outside REQ; at most one memory transaction shall be outstanding.
REQ-033 wb_inst, wb_pc and wb_rd_wr_addr shall always pass through from the accepted instruction.

Reset
REQ-034 While rst_n=0 at a clock edge, the block shall reset:
  - state = IDLE.
  - wb_valid, dm_req, dm_we, wb_ale = 0.
  - all payload registers, dm_addr, dm_wdata, dm_wstrb = 0.
REQ-035 Reset asserted in REQ or RESP shall abandon the transaction with no WB output. dm_rvalid arriving after reset release shall be ignored in IDLE.

Verification
REQ-036 Three NONE ops (ex_result=0x11,0x22,0x33) with wb_ready=1 -> wb_valid on 3 consecutive cycles carrying 0x11,0x22,0x33.
REQ-037 LD_B at 0x1003, dm_rdata=0x80FF_FF7F, gnt after 2 cycles, rvalid 1 cycle later -> dm_addr=0x1000, wb_result=0xFFFF_FF80; LD_BU gives 0x0000_0080.
REQ-038 ST_H at 0x2002 with data 0xABCD_1234 -> dm_we=1, wdata=0x1234_1234, wstrb=1100, wb_rd_wr_en=0.
REQ-039 LD_W at 0x3001 -> no dm_req, wb_ale=1, wb_result=0x3001, wb_rd_wr_en=0.
REQ-040 wb_ready=0 for 4 cycles after a load completes -> ex_ready=0, wb payload stable; wb_ready=1 -> ex_ready=1 in the same cycle.
REQ-041 rst_n=0 while in RESP -> next cycle state IDLE, wb_valid=0; a late dm_rvalid produces no output.

Source files
------------

// File: rtl/mem_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_if : EX -> MEM, MEM <-> data memory and MEM -> WB signal bundle
// Revision     : 1.0
// ---------------------------------------------------------------------------
interface mem_stage_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int INST_WIDTH   = 32,
  parameter int REG_WIDTH    = 5,
  parameter int LSU_OP_WIDTH = 4
);
  logic                    ex_valid;
  logic                    ex_ready;
  logic [INST_WIDTH-1:0]   ex_inst;
  logic [ADDR_WIDTH-1:0]   ex_pc;
  logic [DATA_WIDTH-1:0]   ex_result;
  logic                    ex_rd_wr_en;
  logic [REG_WIDTH-1:0]    ex_rd_wr_addr;
  logic [DATA_WIDTH-1:0]   ex_lsu_data;
  logic [LSU_OP_WIDTH-1:0] ex_lsu_op;

  logic                    dm_req;
  logic                    dm_we;
  logic [ADDR_WIDTH-1:0]   dm_addr;
  logic [DATA_WIDTH-1:0]   dm_wdata;
  logic [3:0]              dm_wstrb;
  logic                    dm_gnt;
  logic                    dm_rvalid;
  logic [DATA_WIDTH-1:0]   dm_rdata;

  logic                    wb_valid;
  logic                    wb_ready;
  logic [INST_WIDTH-1:0]   wb_inst;
  logic [ADDR_WIDTH-1:0]   wb_pc;
  logic [DATA_WIDTH-1:0]   wb_result;
  logic                    wb_rd_wr_en;
  logic [REG_WIDTH-1:0]    wb_rd_wr_addr;
  logic                    wb_ale;

  // master: the memory stage itself (drives dm_* requests and the wb_* payload)
  modport master (
    input  ex_valid, ex_inst, ex_pc, ex_result, ex_rd_wr_en, ex_rd_wr_addr,
           ex_lsu_data, ex_lsu_op, dm_gnt, dm_rvalid, dm_rdata, wb_ready,
    output ex_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
           wb_valid, wb_inst, wb_pc, wb_result, wb_rd_wr_en, wb_rd_wr_addr, wb_ale
  );

  modport slave (
    output ex_valid, ex_inst, ex_pc, ex_result, ex_rd_wr_en, ex_rd_wr_addr,
           ex_lsu_data, ex_lsu_op, dm_gnt, dm_rvalid, dm_rdata, wb_ready,
    input  ex_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
           wb_valid, wb_inst, wb_pc, wb_result, wb_rd_wr_en, wb_rd_wr_addr, wb_ale
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage : pipeline memory stage with load/store unit and WB output register
// Revision  : 1.0
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int INST_WIDTH   = 32,
  parameter int REG_WIDTH    = 5,
  parameter int LSU_OP_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_stage_if.master bus
);
  localparam logic [LSU_OP_WIDTH-1:0] OP_LD_B  = LSU_OP_WIDTH'(1);
  localparam logic [LSU_OP_WIDTH-1:0] OP_LD_H  = LSU_OP_WIDTH'(2);
  localparam logic [LSU_OP_WIDTH-1:0] OP_LD_W  = LSU_OP_WIDTH'(3);
  localparam logic [LSU_OP_WIDTH-1:0] OP_LD_BU = LSU_OP_WIDTH'(4);
  localparam logic [LSU_OP_WIDTH-1:0] OP_LD_HU = LSU_OP_WIDTH'(5);
  localparam logic [LSU_OP_WIDTH-1:0] OP_ST_B  = LSU_OP_WIDTH'(6);
  localparam logic [LSU_OP_WIDTH-1:0] OP_ST_H  = LSU_OP_WIDTH'(7);
  localparam logic [LSU_OP_WIDTH-1:0] OP_ST_W  = LSU_OP_WIDTH'(8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [LSU_OP_WIDTH-1:0] p_op;
  logic [1:0]              p_off;
  logic                    p_rd_wr_en;
  logic [DATA_WIDTH-1:0]   p_addr;

  logic                    ex_is_load;
  logic                    ex_is_store;
  logic                    ex_half;
  logic                    ex_word;
  logic [1:0]              ex_off;
  logic                    ex_misaligned;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   st_wdata;
  logic [3:0]              st_wstrb;
  logic [DATA_WIDTH-1:0]   rd_shift;
  logic [DATA_WIDTH-1:0]   load_data;

  always_comb begin
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
    ex_half     = 1'b0;
    ex_word     = 1'b0;
    case (bus.ex_lsu_op)
      OP_LD_B, OP_LD_BU: ex_is_load = 1'b1;
      OP_LD_H, OP_LD_HU: begin ex_is_load = 1'b1;  ex_half = 1'b1; end
      OP_LD_W:           begin ex_is_load = 1'b1;  ex_word = 1'b1; end
      OP_ST_B:           ex_is_store = 1'b1;
      OP_ST_H:           begin ex_is_store = 1'b1; ex_half = 1'b1; end
      OP_ST_W:           begin ex_is_store = 1'b1; ex_word = 1'b1; end
      default:           ;
    endcase
  end

  assign ex_off        = bus.ex_result[1:0];
  assign ex_misaligned = (ex_half && ex_off[0]) || (ex_word && (ex_off != 2'b00));
  assign bus.ex_ready  = (state == IDLE) && (!bus.wb_valid || bus.wb_ready);
  assign accept        = bus.ex_valid && bus.ex_ready;

  // Narrow stores replicate the datum across every lane; the strobe picks the lane.
  always_comb begin
    if (ex_word) begin
      st_wdata = bus.ex_lsu_data;
      st_wstrb = 4'b1111;
    end else if (ex_half) begin
      st_wdata = {(DATA_WIDTH/16){bus.ex_lsu_data[15:0]}};
      st_wstrb = 4'b0011 << ex_off;
    end else begin
      st_wdata = {(DATA_WIDTH/8){bus.ex_lsu_data[7:0]}};
      st_wstrb = 4'b0001 << ex_off;
    end
  end

  assign rd_shift = bus.dm_rdata >> {p_off, 3'b000};

  always_comb begin
    load_data = bus.dm_rdata;
    case (p_op)
      OP_LD_B:  load_data = {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      OP_LD_BU: load_data = {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
      OP_LD_H:  load_data = {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
      OP_LD_HU: load_data = {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
      default:  load_data = bus.dm_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      p_op              <= '0;
      p_off             <= '0;
      p_rd_wr_en        <= 1'b0;
      p_addr            <= '0;
      bus.dm_req        <= 1'b0;
      bus.dm_we         <= 1'b0;
      bus.dm_addr       <= '0;
      bus.dm_wdata      <= '0;
      bus.dm_wstrb      <= '0;
      bus.wb_valid      <= 1'b0;
      bus.wb_inst       <= '0;
      bus.wb_pc         <= '0;
      bus.wb_result     <= '0;
      bus.wb_rd_wr_en   <= 1'b0;
      bus.wb_rd_wr_addr <= '0;
      bus.wb_ale        <= 1'b0;
    end else begin
      if (bus.wb_valid && bus.wb_ready) begin
        bus.wb_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          // Accepting implies the WB register is empty or draining this cycle,
          // so the pass-through fields may be overwritten right away.
          if (accept) begin
            bus.wb_inst       <= bus.ex_inst;
            bus.wb_pc         <= bus.ex_pc;
            bus.wb_rd_wr_addr <= bus.ex_rd_wr_addr;
            p_op              <= bus.ex_lsu_op;
            p_off             <= ex_off;
            p_rd_wr_en        <= bus.ex_rd_wr_en;
            p_addr            <= bus.ex_result;
            if ((ex_is_load || ex_is_store) && !ex_misaligned) begin
              state        <= REQ;
              bus.dm_req   <= 1'b1;
              bus.dm_we    <= ex_is_store;
              bus.dm_addr  <= {bus.ex_result[ADDR_WIDTH-1:2], 2'b00};
              bus.dm_wdata <= st_wdata;
              bus.dm_wstrb <= ex_is_store ? st_wstrb : 4'b0000;
            end else begin
              bus.wb_valid    <= 1'b1;
              bus.wb_result   <= bus.ex_result;
              bus.wb_rd_wr_en <= bus.ex_rd_wr_en && !ex_misaligned;
              bus.wb_ale      <= ex_misaligned;
            end
          end
        end
        REQ: begin
          if (bus.dm_gnt) begin
            bus.dm_req <= 1'b0;
            bus.dm_we  <= 1'b0;
            if (bus.dm_we) begin
              state           <= IDLE;
              bus.wb_valid    <= 1'b1;
              bus.wb_result   <= p_addr;
              bus.wb_rd_wr_en <= 1'b0;
              bus.wb_ale      <= 1'b0;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.dm_rvalid) begin
            state           <= IDLE;
            bus.wb_valid    <= 1'b1;
            bus.wb_result   <= load_data;
            bus.wb_rd_wr_en <= p_rd_wr_en;
            bus.wb_ale      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_stage : directed and randomized checks of mem_stage against a
//                transaction-level reference model
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_mem_stage;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mem_stage_if bus ();

  mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] result;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic        ale;
  } wb_t;

  // Model: queue of pending WB results plus one outstanding memory access.
  // phase 0 = none, 1 = request on the bus, 2 = awaiting load data.
  wb_t         exp_q[$];
  int          phase;
  logic [31:0] m_addr;
  logic [3:0]  m_op;
  logic        m_store;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  wb_t         m_ent;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [3:0] op, input logic [31:0] rdata,
                                           input int unsigned off);
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    w = rdata >> (8 * off);
    b = w & 32'h0000_00FF;
    h = w & 32'h0000_FFFF;
    case (op)
      4'd1:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      4'd4:    return b;
      4'd2:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      4'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  task automatic model_accept();
    wb_t         e;
    int          sz;
    logic [31:0] a;
    a  = bus.ex_result;
    sz = op_size(bus.ex_lsu_op);
    e  = {bus.ex_inst, bus.ex_pc, a, bus.ex_rd_wr_en, bus.ex_rd_wr_addr, 1'b0};
    if (sz == 0) begin
      exp_q.push_back(e);
    end else if ((a % sz) != 0) begin
      e.rd_en = 1'b0;
      e.ale   = 1'b1;
      exp_q.push_back(e);
    end else begin
      phase   = 1;
      m_addr  = a;
      m_op    = bus.ex_lsu_op;
      m_store = (bus.ex_lsu_op >= 4'd6);
      m_ent   = e;
      if (sz == 1)      m_wdata = (bus.ex_lsu_data & 32'hFF) * 32'h0101_0101;
      else if (sz == 2) m_wdata = (bus.ex_lsu_data & 32'hFFFF) * 32'h0001_0001;
      else              m_wdata = bus.ex_lsu_data;
      m_wstrb = 4'(((1 << sz) - 1) << (a % 4));
    end
  endtask

  // One clock: called just after the inputs are driven on a falling edge.
  task automatic cycle();
    logic exp_rdy;
    #1;
    exp_rdy = (phase == 0) && (exp_q.size() == 0 || bus.wb_ready);
    check("wb_valid", bus.wb_valid, exp_q.size() != 0);
    check("ex_ready", bus.ex_ready, exp_rdy);
    check("dm_req", bus.dm_req, phase == 1);
    if (phase == 1) begin
      check("dm_addr", bus.dm_addr, m_addr & 32'hFFFF_FFFC);
      check("dm_we", bus.dm_we, m_store);
      if (m_store) check("dm_wdata", {bus.dm_wdata, bus.dm_wstrb}, {m_wdata, m_wstrb});
    end
    if (exp_q.size() != 0 && bus.wb_valid) begin
      check("wb_payload", {bus.wb_inst, bus.wb_pc, bus.wb_result, bus.wb_rd_wr_en,
                           bus.wb_rd_wr_addr, bus.wb_ale}, exp_q[0]);
    end
    if (!rst_n) begin
      exp_q.delete();
      phase = 0;
    end else begin
      if (bus.wb_valid && bus.wb_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (phase == 2 && bus.dm_rvalid) begin
        m_ent.result = load_val(m_op, bus.dm_rdata, m_addr % 4);
        exp_q.push_back(m_ent);
        phase = 0;
      end else if (phase == 1 && bus.dm_gnt) begin
        if (m_store) begin
          m_ent.result = m_addr;
          m_ent.rd_en  = 1'b0;
          exp_q.push_back(m_ent);
          phase = 0;
        end else begin
          phase = 2;
        end
      end
      if (bus.ex_valid && exp_rdy) model_accept();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    bus.ex_valid      = 1'b1;
    bus.ex_lsu_op     = op;
    bus.ex_result     = addr;
    bus.ex_lsu_data   = data;
    bus.ex_inst       = $urandom;
    bus.ex_pc         = $urandom;
    bus.ex_rd_wr_en   = 1'b1;
    bus.ex_rd_wr_addr = 5'($urandom_range(0, 31));
    cycle();
    bus.ex_valid = 1'b0;
  endtask

  task automatic grant(input int wait_n);
    repeat (wait_n) cycle();
    bus.dm_gnt = 1'b1;
    cycle();
    bus.dm_gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rd);
    bus.dm_rvalid = 1'b1;
    bus.dm_rdata  = rd;
    cycle();
    bus.dm_rvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] b2b [3];
    n_tests = 0;
    n_fail  = 0;
    phase   = 0;
    b2b[0] = 32'h11; b2b[1] = 32'h22; b2b[2] = 32'h33;
    rst_n = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_inst = '0; bus.ex_pc = '0; bus.ex_result = '0;
    bus.ex_rd_wr_en = 1'b0; bus.ex_rd_wr_addr = '0; bus.ex_lsu_data = '0; bus.ex_lsu_op = '0;
    bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0; bus.dm_rdata = '0; bus.wb_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_out", {bus.wb_valid, bus.dm_req, bus.dm_we, bus.wb_ale, bus.dm_addr,
                        bus.dm_wdata, bus.dm_wstrb, bus.wb_result, bus.wb_rd_wr_en}, '0);
    check("reset_rdy", bus.ex_ready, 1'b1);

    // Back-to-back pass-through ops at full rate
    bus.ex_valid = 1'b1; bus.ex_lsu_op = 4'd0; bus.ex_rd_wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ex_result = b2b[i];
      cycle();
      check("b2b_valid", bus.wb_valid, 1'b1);
      check("b2b_result", bus.wb_result, b2b[i]);
    end
    bus.ex_valid = 1'b0;
    cycle();

    // Signed and unsigned byte loads from the top lane
    issue(4'd1, 32'h0000_1003, 32'h0);
    check("ldb_req", bus.dm_req, 1'b1);
    check("ldb_addr", bus.dm_addr, 32'h0000_1000);
    grant(2);
    check("ldb_req_drop", bus.dm_req, 1'b0);
    respond(32'h80FF_FF7F);
    check("ldb_result", bus.wb_result, 32'hFFFF_FF80);
    cycle();
    issue(4'd4, 32'h0000_1003, 32'h0);
    grant(0);
    respond(32'h80FF_FF7F);
    check("ldbu_result", bus.wb_result, 32'h0000_0080);
    cycle();

    // Halfword store to the upper half
    issue(4'd7, 32'h0000_2002, 32'hABCD_1234);
    check("sth_we", bus.dm_we, 1'b1);
    check("sth_data", {bus.dm_wdata, bus.dm_wstrb}, {32'h1234_1234, 4'b1100});
    grant(1);
    check("sth_wb", {bus.wb_valid, bus.wb_rd_wr_en, bus.wb_result}, {2'b10, 32'h0000_2002});
    cycle();

    // Misaligned word load never reaches memory
    issue(4'd3, 32'h0000_3001, 32'h0);
    check("ale_req", bus.dm_req, 1'b0);
    check("ale_wb", {bus.wb_valid, bus.wb_ale, bus.wb_rd_wr_en, bus.wb_result},
          {3'b110, 32'h0000_3001});
    cycle();

    // Downstream back-pressure after a load
    bus.wb_ready = 1'b0;
    issue(4'd3, 32'h0000_4000, 32'h0);
    grant(0);
    respond(32'h1234_5678);
    bus.ex_valid = 1'b1; bus.ex_lsu_op = 4'd0; bus.ex_result = 32'h55;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stall_rdy", bus.ex_ready, 1'b0);
      check("stall_res", bus.wb_result, 32'h1234_5678);
    end
    bus.wb_ready = 1'b1;
    #1;
    check("release_rdy", bus.ex_ready, 1'b1);
    cycle();
    bus.ex_valid = 1'b0;
    cycle();

    // Reset in the response phase abandons the load
    issue(4'd3, 32'h0000_5000, 32'h0);
    grant(1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("rst_resp", {bus.wb_valid, bus.dm_req, bus.ex_ready}, 3'b001);
    respond(32'hDEAD_BEEF);
    check("late_rvalid", bus.wb_valid, 1'b0);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n             = ($urandom_range(0, 199) != 0);
      bus.wb_ready      = ($urandom_range(0, 9) < 7);
      bus.ex_valid      = $urandom_range(0, 1) == 1;
      bus.ex_lsu_op     = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 8))
                                                     : 4'($urandom_range(9, 15));
      bus.ex_result     = $urandom;
      bus.ex_lsu_data   = $urandom;
      bus.ex_inst       = $urandom;
      bus.ex_pc         = $urandom;
      bus.ex_rd_wr_en   = $urandom_range(0, 1) == 1;
      bus.ex_rd_wr_addr = 5'($urandom_range(0, 31));
      bus.dm_gnt        = bus.dm_req && ($urandom_range(0, 1) == 1);
      bus.dm_rvalid     = ($urandom_range(0, 2) == 0);
      bus.dm_rdata      = $urandom;
      cycle();
    end

    rst_n = 1'b1; bus.ex_valid = 1'b0; bus.wb_ready = 1'b1;
    bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0;
    repeat (4) cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
